counter_seq_checker: RTL and testbench

Sequence checker that sits directly downstream of the 16-bit synchronous counter. It snoops the counter's control inputs (ENB, MODO, D) and its outputs (Q, RCO), and predicts each next count. It flags every cycle in which the counter deviates from its mode contract and keeps saturating error and wrap statistics. It is used both in-system, as a health monitor, and as the self-checking stage of counter benches.

---
 rtl/counter_seq_checker.sv | 129 ++++++++++++
 tb/tb_counter_seq_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_checker.sv
// Sequence checker for the 16-bit up/down/load counter: predicts each next Q/RCO from
// the observed count and controls, flags deviations and keeps saturating statistics.
module counter_seq_checker #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic             RCO,
    input  logic             CLR,
    output logic             LOCKED,
    output logic             MISMATCH,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] WRAP_CNT,
    output logic [WIDTH-1:0] EXP_Q
);

    typedef enum logic [0:0] {StSync, StTrack} state_e;

    state_e             state_q, state_d;
    logic               mismatch_q, mismatch_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
    logic [WIDTH-1:0]   exp_q_q, exp_q_d;
    logic               exp_rco_q, exp_rco_d;

    logic [WIDTH-1:0]   pred_q;
    logic               pred_rco;
    logic               fail;

    // Prediction is always built from the observed Q so one bad value costs one error.
    always_comb begin
        pred_q   = Q;
        pred_rco = 1'b0;
        if (ENB) begin
            unique case (MODO)
                2'b00: begin
                    pred_q   = Q + WIDTH'(1);
                    pred_rco = &Q;
                end
                2'b01: begin
                    pred_q   = Q - WIDTH'(1);
                    pred_rco = (Q == '0);
                end
                2'b10: begin
                    pred_q   = Q - WIDTH'(3);
                    pred_rco = (Q < WIDTH'(3));
                end
                default: begin
                    pred_q   = D;
                    pred_rco = 1'b0;
                end
            endcase
        end
    end

    assign fail = (Q != exp_q_q) || (RCO != exp_rco_q);

    always_comb begin
        state_d    = state_q;
        mismatch_d = 1'b0;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        exp_q_d    = exp_q_q;
        exp_rco_d  = exp_rco_q;

        if (CLR) begin
            state_d    = StSync;
            err_d      = 1'b0;
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else begin
            unique case (state_q)
                StSync: begin
                    if (ENB && (MODO == 2'b11)) begin
                        state_d   = StTrack;
                        exp_q_d   = D;
                        exp_rco_d = 1'b0;
                    end
                end
                default: begin
                    if (fail) begin
                        mismatch_d = 1'b1;
                        err_d      = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (RCO && (wrap_cnt_q != '1)) wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                    exp_q_d   = pred_q;
                    exp_rco_d = pred_rco;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StSync;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
            exp_q_q    <= '0;
            exp_rco_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
            exp_q_q    <= exp_q_d;
            exp_rco_q  <= exp_rco_d;
        end
    end

    assign LOCKED   = (state_q == StTrack);
    assign MISMATCH = mismatch_q;
    assign ERR      = err_q;
    assign ERR_CNT  = err_cnt_q;
    assign WRAP_CNT = wrap_cnt_q;
    assign EXP_Q    = exp_q_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Self-checking bench for counter_seq_checker: the bench plays the counter, optionally
// corrupts Q/RCO, and scoreboards the checker outputs against its own model.
module tb_counter_seq_checker;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENB;
    logic [1:0]  MODO;
    logic [15:0] D;
    logic [15:0] Q;
    logic        RCO;
    logic        CLR;
    logic        LOCKED;
    logic        MISMATCH;
    logic        ERR;
    logic [7:0]  ERR_CNT;
    logic [7:0]  WRAP_CNT;
    logic [15:0] EXP_Q;

    counter_seq_checker #(.WIDTH(16), .CNT_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENB      (ENB),
        .MODO     (MODO),
        .D        (D),
        .Q        (Q),
        .RCO      (RCO),
        .CLR      (CLR),
        .LOCKED   (LOCKED),
        .MISMATCH (MISMATCH),
        .ERR      (ERR),
        .ERR_CNT  (ERR_CNT),
        .WRAP_CNT (WRAP_CNT),
        .EXP_Q    (EXP_Q)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        locked;
        logic        mismatch;
        logic        err;
        logic [7:0]  ecnt;
        logic [7:0]  wcnt;
        logic [15:0] expq;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Counter under emulation and checker reference model.
    logic [15:0] cnt;
    logic        cnt_rco;
    logic        m_track, m_mis, m_err, m_exp_rco;
    logic [7:0]  m_ecnt, m_wcnt;
    logic [15:0] m_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Counter contract with carry/borrow taken from 17-bit arithmetic.
    task automatic contract(input logic [15:0] q, input logic enb, input logic [1:0] modo,
                            input logic [15:0] d, output logic [15:0] nq, output logic nrco);
        logic [16:0] t;
        nq   = q;
        nrco = 1'b0;
        if (enb) begin
            case (modo)
                2'b00: begin t = {1'b0, q} + 17'd1; nq = t[15:0]; nrco = t[16]; end
                2'b01: begin t = {1'b0, q} - 17'd1; nq = t[15:0]; nrco = t[16]; end
                2'b10: begin t = {1'b0, q} - 17'd3; nq = t[15:0]; nrco = t[16]; end
                default: begin nq = d; nrco = 1'b0; end
            endcase
        end
    endtask

    task automatic model_reset();
        m_track = 0; m_mis = 0; m_err = 0; m_exp_rco = 0;
        m_ecnt = 0; m_wcnt = 0; m_exp = 16'h0000;
    endtask

    // One clock: drive, push expectation, wait edge, pop and compare.
    task automatic step(input logic enb, input logic [1:0] modo, input logic [15:0] d,
                        input logic clr, input logic fq, input logic [15:0] qv,
                        input logic frco);
        logic [15:0] q_drv;
        logic        rco_drv, bad;
        exp_t        e;
        q_drv   = fq ? qv : cnt;
        rco_drv = frco ? 1'b1 : cnt_rco;
        ENB = enb; MODO = modo; D = d; CLR = clr; Q = q_drv; RCO = rco_drv;
        if (clr) begin
            m_track = 0; m_mis = 0; m_err = 0; m_ecnt = 0; m_wcnt = 0;
        end else if (!m_track) begin
            m_mis = 0;
            if (enb && modo == 2'b11) begin
                m_track = 1; m_exp = d; m_exp_rco = 0;
            end
        end else begin
            bad   = (q_drv !== m_exp) || (rco_drv !== m_exp_rco);
            m_mis = bad;
            if (bad) begin
                m_err = 1;
                if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
            end
            if (rco_drv && m_wcnt != 8'hFF) m_wcnt = m_wcnt + 8'd1;
            contract(q_drv, enb, modo, d, m_exp, m_exp_rco);
        end
        contract(q_drv, enb, modo, d, cnt, cnt_rco);
        sb.push_back('{m_track, m_mis, m_err, m_ecnt, m_wcnt, m_exp});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check("locked",   32'(LOCKED),   32'(e.locked));
        check("mismatch", 32'(MISMATCH), 32'(e.mismatch));
        check("err",      32'(ERR),      32'(e.err));
        check("err_cnt",  32'(ERR_CNT),  32'(e.ecnt));
        check("wrap_cnt", 32'(WRAP_CNT), 32'(e.wcnt));
        check("exp_q",    32'(EXP_Q),    32'(e.expq));
    endtask

    task automatic go(input logic enb, input logic [1:0] modo, input logic [15:0] d);
        step(enb, modo, d, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},   32'(LOCKED),   0);
        check({tag, "_mismatch"}, 32'(MISMATCH), 0);
        check({tag, "_err"},      32'(ERR),      0);
        check({tag, "_err_cnt"},  32'(ERR_CNT),  0);
        check({tag, "_wrap_cnt"}, 32'(WRAP_CNT), 0);
        check({tag, "_exp_q"},    32'(EXP_Q),    0);
    endtask

    initial begin
        RESET = 1'b1; ENB = 0; MODO = 0; D = 0; Q = 0; RCO = 0; CLR = 0;
        cnt = 16'h1234; cnt_rco = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        RESET = 1'b0;
        @(posedge CLK); #1;

        // No lock without a load.
        go(1, 2'b00, 16'h0);
        go(1, 2'b01, 16'h0);
        // Up count from 0.
        go(1, 2'b11, 16'h0000);
        for (int i = 0; i < 20; i++) go(1, 2'b00, 16'h0);
        check("up_exp_q", 32'(EXP_Q), 32'h14);
        check("up_locked", 32'(LOCKED), 1);
        check("up_err_cnt", 32'(ERR_CNT), 0);

        // Wrap up through all-ones.
        go(1, 2'b11, 16'hFFFE);
        go(1, 2'b00, 16'h0);
        go(1, 2'b00, 16'h0);
        go(1, 2'b00, 16'h0);
        check("wrap_up_cnt", 32'(WRAP_CNT), 1);
        check("wrap_up_err", 32'(ERR), 0);
        // Wrap down by 3 from 1.
        go(1, 2'b11, 16'h0004);
        go(1, 2'b10, 16'h0);
        go(1, 2'b10, 16'h0);
        go(1, 2'b01, 16'h0);
        check("wrap_dn_cnt", 32'(WRAP_CNT), 2);
        check("wrap_dn_err", 32'(ERR), 0);

        // Single corrupted Q, then tracking resumes.
        go(1, 2'b11, 16'h0004);
        go(1, 2'b00, 16'h0);
        check("pre_fault_exp", 32'(EXP_Q), 32'h5);
        step(1, 2'b00, 16'h0, 1'b0, 1'b1, 16'h0010, 1'b0);
        check("fault_mis", 32'(MISMATCH), 1);
        check("fault_cnt", 32'(ERR_CNT), 1);
        check("fault_next_exp", 32'(EXP_Q), 32'h11);
        go(1, 2'b00, 16'h0);
        check("fault_mis_drop", 32'(MISMATCH), 0);
        check("fault_cnt_hold", 32'(ERR_CNT), 1);

        // Q moves while disabled.
        go(1, 2'b11, 16'h0007);
        go(0, 2'b00, 16'h0);
        step(0, 2'b00, 16'h0, 1'b0, 1'b1, 16'h0008, 1'b0);
        go(1, 2'b00, 16'h0);
        check("hold_err_cnt", 32'(ERR_CNT), 2);
        // Spurious RCO.
        step(1, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        check("rco_err_cnt", 32'(ERR_CNT), 3);
        check("rco_wrap_cnt", 32'(WRAP_CNT), 3);

        // Asynchronous reset between edges.
        #2;
        RESET = 1'b1;
        #1;
        check_all_zero("async");
        model_reset();
        #1;
        RESET = 1'b0;
        go(1, 2'b00, 16'h0);
        go(1, 2'b00, 16'h0);
        check("post_rst_locked", 32'(LOCKED), 0);
        go(1, 2'b11, 16'h0100);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) step(1, 2'b00, 16'h0, 1'b0, 1'b1, m_exp ^ 16'h8000, 1'b0);
        check("sat_err_cnt", 32'(ERR_CNT), 255);
        check("sat_mis", 32'(MISMATCH), 1);

        // Clear wins over a coincident load.
        step(1, 2'b11, 16'h0ABC, 1'b1, 1'b0, 16'h0, 1'b0);
        check("clr_locked", 32'(LOCKED), 0);
        check("clr_err_cnt", 32'(ERR_CNT), 0);
        check("clr_err", 32'(ERR), 0);
        go(1, 2'b00, 16'h0);
        check("clr_still_sync", 32'(LOCKED), 0);
        go(1, 2'b11, 16'h0ABC);
        check("relock", 32'(LOCKED), 1);
        go(1, 2'b00, 16'h0);
        go(1, 2'b00, 16'h0);
        check("relock_err", 32'(ERR), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
